// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the counter/RAM logging sequencer.
package cnt_seq_pkg;

  localparam int STEP_W_DEF = 4;
  localparam int ADDR_W_DEF = 3;

  localparam logic [3:0] CNT_MAX  = 4'd7;
  localparam logic [3:0] WRAP_SAT = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_LAST   = 3'd3,
    ST_DONE_S = 3'd4
  } seq_state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    logic [3:0] r;
    if (v == WRAP_SAT) begin
      r = WRAP_SAT;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_ram_seq.sv
// Sequencer: preloads the mod-8 counter, steps it, logs every observed count
// into an 8x4 RAM and counts wrap-arounds of the counter.
module cnt_ram_seq
  import cnt_seq_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [3:0]        START_VAL,
  input  logic [STEP_W-1:0] STEPS,
  output logic              BUSY,
  output logic              DONE,
  output logic [3:0]        WRAPS,
  output logic              CNT_EN,
  output logic              CNT_LOAD_N,
  output logic [3:0]        CNT_DATA,
  input  logic [3:0]        CNT_Q,
  input  logic              CNT_COUT,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [3:0]        RAM_WDATA
);

  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_ZERO = STEP_W'(0);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [3:0]        r_val;
  logic [STEP_W-1:0] r_steps;
  logic [STEP_W-1:0] r_idx;
  logic [3:0]        r_wraps;
  logic              w_accept;
  logic              w_last_run;

  // COUT is observation-only; control derives wraps from CNT_Q directly.
  logic w_unused_cout;
  assign w_unused_cout = CNT_COUT;

  assign w_accept   = START && !ABORT;
  assign w_last_run = (r_idx == (r_steps - STEP_ONE));

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; ABORT in any busy state returns straight to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else if (r_steps != STEP_ZERO) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_LAST;
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last_run) begin
          w_state_nxt = ST_LAST;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LAST: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE_S;
        end
      end
      ST_DONE_S: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Run parameters, step index and wrap counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_val   <= 4'd0;
      r_steps <= STEP_ZERO;
      r_idx   <= STEP_ZERO;
      r_wraps <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_val   <= START_VAL;
            r_steps <= STEPS;
            r_idx   <= STEP_ZERO;
            r_wraps <= 4'd0;
          end
        end
        ST_RUN: begin
          // The counter is enabled this cycle even if ABORT arrives, so a
          // wrap at this edge still happens and is still counted.
          r_idx <= r_idx + STEP_ONE;
          if (CNT_Q >= CNT_MAX) begin
            r_wraps <= sat_inc4(r_wraps);
          end
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  // Moore output decode of the registered state.
  always_comb begin
    BUSY       = 1'b0;
    DONE       = 1'b0;
    CNT_EN     = 1'b0;
    CNT_LOAD_N = 1'b1;
    CNT_DATA   = 4'd0;
    RAM_WE     = 1'b0;
    RAM_ADDR   = {ADDR_W{1'b0}};
    case (r_state)
      ST_LOAD: begin
        BUSY       = 1'b1;
        CNT_EN     = 1'b1;
        CNT_LOAD_N = 1'b0;
        CNT_DATA   = r_val;
      end
      ST_RUN: begin
        BUSY     = 1'b1;
        CNT_EN   = 1'b1;
        RAM_WE   = 1'b1;
        RAM_ADDR = r_idx[ADDR_W-1:0];
      end
      ST_LAST: begin
        BUSY     = 1'b1;
        RAM_WE   = 1'b1;
        RAM_ADDR = r_idx[ADDR_W-1:0];
      end
      ST_DONE_S: begin
        DONE = 1'b1;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  assign WRAPS     = r_wraps;
  assign RAM_WDATA = CNT_Q;

endmodule

// File: tb/tb_cnt_ram_seq.sv
// Directed bench: models the mod-8 counter and 8x4 RAM around the sequencer.
module tb_cnt_ram_seq;

  logic       CLK;
  logic       RESET_N;
  logic       START;
  logic       ABORT;
  logic [3:0] START_VAL;
  logic [3:0] STEPS;
  logic       BUSY;
  logic       DONE;
  logic [3:0] WRAPS;
  logic       CNT_EN;
  logic       CNT_LOAD_N;
  logic [3:0] CNT_DATA;
  logic [3:0] CNT_Q;
  logic       CNT_COUT;
  logic       RAM_WE;
  logic [2:0] RAM_ADDR;
  logic [3:0] RAM_WDATA;

  int n_pass;
  int n_total;

  logic [3:0] tb_ram [8];
  logic [4:0] wr_cnt;
  logic       ram_clr;

  cnt_ram_seq #(.STEP_W(4), .ADDR_W(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
    .START_VAL(START_VAL), .STEPS(STEPS), .BUSY(BUSY), .DONE(DONE),
    .WRAPS(WRAPS), .CNT_EN(CNT_EN), .CNT_LOAD_N(CNT_LOAD_N),
    .CNT_DATA(CNT_DATA), .CNT_Q(CNT_Q), .CNT_COUT(CNT_COUT),
    .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Mod-8 loadable counter model.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CNT_Q <= 4'd0;
    end else if (CNT_EN) begin
      if (!CNT_LOAD_N) CNT_Q <= CNT_DATA;
      else if (CNT_Q >= 4'd7) CNT_Q <= 4'd0;
      else CNT_Q <= CNT_Q + 4'd1;
    end
  end
  assign CNT_COUT = CNT_EN && (CNT_Q == 4'd7);

  // RAM model with write counter; ram_clr fills it with 4'hE.
  always_ff @(posedge CLK) begin
    if (ram_clr) begin
      for (int i = 0; i < 8; i++) tb_ram[i] <= 4'hE;
      wr_cnt <= 5'd0;
    end else if (RAM_WE) begin
      tb_ram[RAM_ADDR] <= RAM_WDATA;
      wr_cnt <= wr_cnt + 5'd1;
    end
  end

  typedef struct {
    logic [3:0]  sv;
    logic [3:0]  st;
    logic [3:0]  wraps;
    logic [4:0]  writes;
    logic [31:0] ram;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] ram_packed();
    logic [31:0] p;
    for (int i = 0; i < 8; i++) p[4*i +: 4] = tb_ram[i];
    return p;
  endfunction

  task automatic clear_ram();
    ram_clr = 1'b1;
    @(negedge CLK);
    ram_clr = 1'b0;
  endtask

  // Issue START before edge e0; returns at the negedge of cycle 1.
  task automatic kick(input logic [3:0] sv, input logic [3:0] st);
    START_VAL = sv;
    STEPS     = st;
    START     = 1'b1;
    @(negedge CLK);
    START     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [19:0] busy_seq, busy_exp, done_seq, done_exp;
    int last;
    busy_seq = '0; busy_exp = '0; done_seq = '0; done_exp = '0;
    last = int'(v.st) + 4;
    clear_ram();
    kick(v.sv, v.st);
    for (int k = 1; k <= last; k++) begin
      busy_seq[k] = BUSY;
      done_seq[k] = DONE;
      busy_exp[k] = (k <= int'(v.st) + 2);
      done_exp[k] = (k == int'(v.st) + 3);
      if (k == 1) begin
        chk($sformatf("v%0d load_n", id), {31'd0, CNT_LOAD_N}, 32'd0);
        chk($sformatf("v%0d cnt_data", id), {28'd0, CNT_DATA}, {28'd0, v.sv});
      end
      if (k == int'(v.st) + 3) chk($sformatf("v%0d wraps", id), {28'd0, WRAPS}, {28'd0, v.wraps});
      @(negedge CLK);
    end
    chk($sformatf("v%0d busy_seq", id), {12'd0, busy_seq}, {12'd0, busy_exp});
    chk($sformatf("v%0d done_seq", id), {12'd0, done_seq}, {12'd0, done_exp});
    chk($sformatf("v%0d writes", id), {27'd0, wr_cnt}, {27'd0, v.writes});
    chk($sformatf("v%0d ram", id), ram_packed(), v.ram);
  endtask

  initial begin
    logic [19:0] seq_b, seq_d;
    n_pass = 0; n_total = 0;
    RESET_N = 1'b0; START = 1'b0; ABORT = 1'b0;
    START_VAL = 4'd0; STEPS = 4'd0; ram_clr = 1'b1;

    vecs[0] = '{sv: 4'd5,  st: 4'd4,  wraps: 4'd1, writes: 5'd5,  ram: 32'hEEE1_0765};
    vecs[1] = '{sv: 4'd3,  st: 4'd0,  wraps: 4'd0, writes: 5'd1,  ram: 32'hEEEE_EEE3};
    vecs[2] = '{sv: 4'd0,  st: 4'd12, wraps: 4'd1, writes: 5'd13, ram: 32'h7654_3210};
    vecs[3] = '{sv: 4'd10, st: 4'd2,  wraps: 4'd1, writes: 5'd3,  ram: 32'hEEEE_E10A};
    vecs[4] = '{sv: 4'd7,  st: 4'd15, wraps: 4'd2, writes: 5'd16, ram: 32'h6543_2107};

    @(negedge CLK);
    @(negedge CLK);
    chk("rst busy",   {31'd0, BUSY},       32'd0);
    chk("rst done",   {31'd0, DONE},       32'd0);
    chk("rst wraps",  {28'd0, WRAPS},      32'd0);
    chk("rst cnt_en", {31'd0, CNT_EN},     32'd0);
    chk("rst load_n", {31'd0, CNT_LOAD_N}, 32'd1);
    chk("rst ram_we", {31'd0, RAM_WE},     32'd0);
    RESET_N = 1'b1;
    ram_clr = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // ABORT in the 2nd RUN cycle (cycle 3).
    clear_ram();
    kick(4'd0, 4'd6);
    @(negedge CLK);
    @(negedge CLK);
    chk("abort pre busy", {31'd0, BUSY}, 32'd1);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("abort busy",   {31'd0, BUSY},   32'd0);
    chk("abort ram_we", {31'd0, RAM_WE}, 32'd0);
    chk("abort cnt_en", {31'd0, CNT_EN}, 32'd0);
    seq_d = '0;
    for (int k = 0; k < 6; k++) begin
      seq_d[k] = DONE;
      @(negedge CLK);
    end
    chk("abort no done", {12'd0, seq_d}, 32'd0);
    chk("abort writes",  {27'd0, wr_cnt}, 32'd2);
    chk("abort ram",     ram_packed(), 32'hEEEE_EE10);

    // START while busy is ignored.
    clear_ram();
    kick(4'd1, 4'd2);
    seq_b = '0; seq_d = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin START_VAL = 4'd6; STEPS = 4'd9; START = 1'b1; end
      if (k == 4) START = 1'b0;
      seq_b[k] = BUSY;
      seq_d[k] = DONE;
      @(negedge CLK);
    end
    chk("busy start busy_seq", {12'd0, seq_b}, 32'h0000_001E);
    chk("busy start done_seq", {12'd0, seq_d}, 32'h0000_0020);
    chk("busy start ram",      ram_packed(),   32'hEEEE_E321);

    // START together with ABORT in IDLE.
    START = 1'b1; ABORT = 1'b1; START_VAL = 4'd2; STEPS = 4'd3;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    seq_b = '0;
    for (int k = 0; k < 4; k++) begin
      seq_b[k] = BUSY | !CNT_LOAD_N | CNT_EN;
      @(negedge CLK);
    end
    chk("start+abort idle", {12'd0, seq_b}, 32'd0);

    // Reset asserted in the 3rd RUN cycle (cycle 4).
    clear_ram();
    kick(4'd0, 4'd6);
    for (int k = 1; k < 4; k++) @(negedge CLK);
    chk("prerst writes", {27'd0, wr_cnt}, 32'd2);
    RESET_N = 1'b0;
    #1;
    chk("midrst busy",   {31'd0, BUSY},       32'd0);
    chk("midrst cnt_en", {31'd0, CNT_EN},     32'd0);
    chk("midrst load_n", {31'd0, CNT_LOAD_N}, 32'd1);
    chk("midrst ram_we", {31'd0, RAM_WE},     32'd0);
    chk("midrst addr",   {29'd0, RAM_ADDR},   32'd0);
    chk("midrst wraps",  {28'd0, WRAPS},      32'd0);
    chk("midrst wdata",  {28'd0, RAM_WDATA},  32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    run_vec(vecs[0], 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
